d_mem: RTL and testbench

- Word-organised data memory for the pipelined 32-bit CPU; sits in the MEM stage.
- Address comes from the ALU result; write data comes from the forwarded register-B value.
- Reads are combinational, so the MEM/WB pipeline register can capture data_out in the same cycle.
- Writes commit on the rising clock edge when WrEn is high.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/d_mem.sv | 36 +++
 tb/tb_d_mem.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath word width, byte-offset width, default data memory depth.
package cpu_pkg;
    localparam int WORD_W        = 32;
    localparam int BYTE_OFFSET_W = 2;
    localparam int DMEM_DEPTH    = 256;
endpackage

// File: rtl/d_mem.sv
// Word-organised MEM-stage data memory. Reads are combinational with zero latency; writes and reset take effect on posedge.
// There is no handshake and no backpressure: every access completes, and synchronous reset clears all words and blocks a write in the same cycle.
module d_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       adr,
    input  logic [WORD_W-1:0] data_in,
    input  logic              WrEn,
    output logic [WORD_W-1:0] data_out
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused_adr_bits;

    // Byte offset and high bits are dropped: misaligned accesses hit the containing word, and high addresses alias.
    assign w_idx             = adr[ADDR_W+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
    assign w_unused_adr_bits = ^{adr[31:ADDR_W+BYTE_OFFSET_W], adr[BYTE_OFFSET_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (WrEn) begin
            r_mem[w_idx] <= data_in;
        end
    end

    assign data_out = r_mem[w_idx];
endmodule

// File: tb/tb_d_mem.sv
// Directed-vector bench for d_mem covering reset, write/read, alignment, aliasing, read-during-write, hold and mid-run reset.
module tb_d_mem;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] data_in;
    logic        WrEn;
    logic [31:0] data_out;

    int vectors;
    int miscompares;

    d_mem #(.DEPTH(DMEM_DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .adr      (adr),
        .data_in  (data_in),
        .WrEn     (WrEn),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on negedge; the write commits on the following posedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        adr     = a;
        data_in = d;
        WrEn    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        WrEn = 1'b0;
        adr  = a;
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset asserted with a pending write; reset must win.
        rst_n   = 1'b0;
        WrEn    = 1'b1;
        data_in = 32'hDEAD_BEEF;
        adr     = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        WrEn  = 1'b0;
        for (int a = 0; a < DMEM_DEPTH * 4; a += 4) begin
            rd($sformatf("reset_sweep_%0h", a), 32'(a), 32'h0);
        end

        wr(32'h10, 32'h1234_5678);
        wr(32'h14, 32'hCAFE_F00D);
        rd("rd_10", 32'h10, 32'h1234_5678);
        rd("rd_14", 32'h14, 32'hCAFE_F00D);
        rd("rd_18", 32'h18, 32'h0);

        wr(32'h23, 32'hA5A5_A5A5);
        rd("misalign_20", 32'h20, 32'hA5A5_A5A5);
        rd("misalign_22", 32'h22, 32'hA5A5_A5A5);
        rd("alias_420", 32'h420, 32'hA5A5_A5A5);
        rd("neighbour_24", 32'h24, 32'h0);
        rd("neighbour_1c", 32'h1C, 32'h0);

        wr(32'h40, 32'h1111_1111);
        @(negedge clk);
        adr     = 32'h40;
        data_in = 32'h2222_2222;
        WrEn    = 1'b1;
        #1;
        check("rdw_before_edge", data_out, 32'h1111_1111);
        @(posedge clk);
        #1;
        check("rdw_after_edge", data_out, 32'h2222_2222);

        @(negedge clk);
        WrEn    = 1'b0;
        data_in = 32'hFFFF_FFFF;
        adr     = 32'h40;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_cycle_%0d", c), data_out, 32'h2222_2222);
        end

        // Back-to-back writes, one per cycle.
        for (int i = 0; i < 16; i++) begin
            wr(32'(i * 4), 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("fill_%0d", i), 32'(i * 4), 32'(i));
        end

        @(negedge clk);
        WrEn  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("midreset_%0d", i), 32'(i * 4), 32'h0);
        end
        rd("midreset_40", 32'h40, 32'h0);
        rd("midreset_10", 32'h10, 32'h0);

        wr(32'h1C, 32'h7);
        rd("post_reset_1c", 32'h1C, 32'h7);
        rd("post_reset_18", 32'h18, 32'h0);
        rd("post_reset_20", 32'h20, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
